disp_chan_scheduler: RTL and testbench
======================================

// Module: disp_chan_scheduler
// PURPOSE
//  Sequences the 8-channel 32-bit display multiplexer by driving its channel select (Test) and its CPU-latch enable (EN).
//  Provides three modes:
//   - manual: channel follows switches.
//   - auto-rotate: each channel is shown for a programmable dwell time.
//   - request-pinned: a channel whose source raises req is shown for HOLD_CYC cycles, arbitrated round-robin.
//  Sits between the switch/CPU control logic and the display mux.
// PARAMETERS
//  DWELL_W   26        width of the dwell counter / dwell_cyc input
//  HOLD_CYC  50000000  cycles a request-pinned channel stays selected (>=1)
// PORTS
//  clk        in   1        system clock, rising edge
//  rst        in   1        asynchronous, active-low reset
//  auto_en    in   1        1 = auto (rotate/pin) mode, 0 = manual mode
//  man_sel    in   3        manual channel select
//  dwell_cyc  in   DWELL_W  rotate dwell in cycles; 0 treated as 1
//  req        in   8        per-channel attention request, level; rising edge is the event
//  cpu_wr     in   1        CPU wrote channel-0 data/blink/point
//  freeze     in   1        1 = suppress EN strobes, hold current Test
//  Test       out  3        channel select to display mux, registered
//  EN         out  1        one-cycle latch strobe for channel-0 registers
//  grant      out  8        one-hot of channel currently pinned; 0 when not in PIN
//  pending    out  8        sticky request flags not yet served
// BEHAVIOUR
//  Reset (rst=0, async): Test=0, EN=0, grant=0, pending=0, state=MANUAL, dwell_cnt=0, hold_cnt=0, rot_ptr=0, rr_ptr=0.
//  Clock: single clock domain; all outputs registered; no combinational input->output path.
//  Request capture (every cycle, all states)
//   - req_d <= req; edge = req & ~req_d.
//   - pending |= edge, cleared per rules below.
//   - Set and clear of the same bit in the same cycle: set wins.
//  States: MANUAL, ROTATE, PIN.
//  MANUAL
//   - Test <= man_sel; 1-cycle latency.
//   - auto_en=1 -> ROTATE, rot_ptr <= man_sel, dwell_cnt <= 0.
//   - pending still accumulates but is not served.
//  ROTATE
//   - dwell_cnt increments each cycle.
//   - When dwell_cnt+1 >= max(dwell_cyc,1): rot_ptr <= rot_ptr+1 (7 wraps to 0), dwell_cnt <= 0.
//   - Test <= rot_ptr.
//   - A change of dwell_cyc mid-count takes effect immediately (compare, not reload).
//   - pending!=0 -> PIN next cycle. Granted channel = first set bit of pending searching upward from rr_ptr, wrapping.
//     Then Test <= ch, grant <= onehot(ch), hold_cnt <= 0.
//  PIN
//   - hold_cnt increments each cycle.
//   - On hold_cnt == HOLD_CYC-1: clear pending[ch], rr_ptr <= ch+1, grant <= 0.
//     Then, if other pending bits remain, PIN on the next winner; otherwise ROTATE, resuming at saved rot_ptr with dwell_cnt=0.
//   - A new edge on the pinned channel during PIN re-sets its pending bit after the clear, so it is served again in a later round.
//  Mode exit: auto_en=0 in ROTATE or PIN -> MANUAL next cycle; grant <= 0, pending <= 0, hold_cnt <= 0.
//  freeze=1
//   - All counters and state hold; Test holds.
//   - EN forced 0; pending still captures edges.
//   - Deassert resumes exactly where stopped.
//  EN
//   - Pulses 1 cycle, the cycle after a cpu_wr rising edge, if freeze=0.
//   - A cpu_wr edge while freeze=1 is dropped, not deferred.
//   - Independent of state.
//  Widths: dwell_cnt DWELL_W bits; hold_cnt is clog2(HOLD_CYC) bits; the pointers are 3 bits and wrap modulo 8.
// STRUCTURE
//  Shared package/header disp_sched_pkg: state encodings (MANUAL=2'd0, ROTATE=2'd1, PIN=2'd2), NCH=8, CH_W=3.
//  One sub-module: rr_pick8
//   - Combinational.
//   - Inputs: pending[7:0], rr_ptr[2:0].
//   - Outputs: found, ch[2:0].
//  Top holds edge detect, FSM, counters and the EN pulse.
// TESTING (sim with DWELL_W=8, HOLD_CYC=4)
//  1. rst low, then high with auto_en=0, man_sel=5.
//     -> Test=0 during reset; Test=5 one cycle after release; grant=0.
//  2. auto_en=1, man_sel=6, dwell_cyc=3.
//     -> Test steps 6,7,0,1, holding 3 cycles each; dwell_cyc=0 -> Test changes every cycle.
//  3. In ROTATE at ch2, pulse req[4] and req[1] in the same cycle.
//     -> Pinned to ch4 for 4 cycles, with grant=8'h10, pending=8'h12.
//     -> Then ch1 for 4 cycles, with grant=8'h02.
//     -> Then ROTATE resumes at ch2 with a full dwell.
//  4. During PIN on ch4, drop auto_en.
//     -> Next cycle MANUAL: Test=man_sel, grant=0, pending=0.
//  5. cpu_wr high for 5 cycles -> exactly one EN pulse.
//     Repeat with freeze=1 -> no EN, Test frozen, pending still captures req.
//  6. Assert rst mid-PIN, asynchronous to clk.
//     -> All outputs are at their reset values before the next edge.

Source files
------------

// File: rtl/disp_sched_pkg.sv
// rtl/disp_sched_pkg.sv - shared types and constants for the display channel scheduler
package disp_sched_pkg;

    localparam int NCH  = 8;
    localparam int CH_W = 3;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        ROTATE = 2'd1,
        PIN    = 2'd2
    } sched_state_t;

    function automatic logic [NCH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
        logic [NCH-1:0] v;
        v     = '0;
        v[ch] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - round-robin picker: first set pending bit at or above rr_ptr, wrapping
module rr_pick8
    import disp_sched_pkg::*;
(
    input  logic [NCH-1:0]  pending,
    input  logic [CH_W-1:0] rr_ptr,
    output logic            found,
    output logic [CH_W-1:0] ch
);

    // scan downward in distance so the nearest set bit from rr_ptr is the last one written
    always_comb begin
        logic [CH_W-1:0] idx;
        found = 1'b0;
        ch    = '0;
        idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = rr_ptr + CH_W'(i);
            if (pending[idx]) begin
                found = 1'b1;
                ch    = idx;
            end
        end
    end

endmodule

// File: rtl/disp_chan_scheduler.sv
// rtl/disp_chan_scheduler.sv - display channel sequencer: manual, auto-rotate and request-pinned modes
module disp_chan_scheduler
    import disp_sched_pkg::*;
#(
    parameter int DWELL_W  = 26,
    parameter int HOLD_CYC = 50000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               auto_en,
    input  logic [CH_W-1:0]    man_sel,
    input  logic [DWELL_W-1:0] dwell_cyc,
    input  logic [NCH-1:0]     req,
    input  logic               cpu_wr,
    input  logic               freeze,
    output logic [CH_W-1:0]    Test,
    output logic               EN,
    output logic [NCH-1:0]     grant,
    output logic [NCH-1:0]     pending
);

    localparam int                HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [DWELL_W:0]  DWELL_ONE = (DWELL_W + 1)'(1);

    sched_state_t       state_q;
    sched_state_t       state_d;
    logic [NCH-1:0]     req_d;
    logic [NCH-1:0]     req_edge;
    logic               cpu_wr_d;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_nx;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [HOLD_W-1:0]  hold_nx;
    logic [CH_W-1:0]    rot_ptr;
    logic [CH_W-1:0]    rot_nx;
    logic [CH_W-1:0]    rr_ptr;
    logic [CH_W-1:0]    rr_nx;
    logic [CH_W-1:0]    test_nx;
    logic [NCH-1:0]     grant_nx;
    logic [NCH-1:0]     pend_clr;
    logic [NCH-1:0]     pin_mask;
    logic [NCH-1:0]     pick_pend;
    logic [CH_W-1:0]    pick_ptr;
    logic [CH_W-1:0]    pick_ch;
    logic               pick_found;
    logic               hold_done;
    logic               dwell_done;
    logic [DWELL_W:0]   dwell_lim;
    logic [DWELL_W:0]   dwell_inc;

    assign req_edge   = req & ~req_d;
    assign pin_mask   = ch_onehot(Test);
    assign hold_done  = (hold_cnt == HOLD_LAST);
    assign dwell_lim  = (dwell_cyc == '0) ? DWELL_ONE : {1'b0, dwell_cyc};
    assign dwell_inc  = {1'b0, dwell_cnt} + DWELL_ONE;
    assign dwell_done = (dwell_inc >= dwell_lim);

    // in PIN the next winner is searched past the channel being released, excluding it
    always_comb begin
        pick_pend = pending;
        pick_ptr  = rr_ptr;
        if (state_q == PIN) begin
            pick_pend = pending & ~pin_mask;
            pick_ptr  = Test + 3'd1;
        end
    end

    rr_pick8 u_pick (
        .pending (pick_pend),
        .rr_ptr  (pick_ptr),
        .found   (pick_found),
        .ch      (pick_ch)
    );

    // request edge capture; a new edge beats a clear of the same bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_d   <= '0;
            pending <= '0;
        end else begin
            req_d   <= req;
            pending <= (pending & ~pend_clr) | req_edge;
        end
    end

    // latch strobe one cycle after a cpu_wr rising edge; edges seen while frozen are dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_wr_d <= 1'b0;
            EN       <= 1'b0;
        end else begin
            cpu_wr_d <= cpu_wr;
            EN       <= cpu_wr & ~cpu_wr_d & ~freeze;
        end
    end

    // mode state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MANUAL;
        end else begin
            state_q <= state_d;
        end
    end

    // next mode; freeze holds everything
    always_comb begin
        state_d = state_q;
        if (!freeze) begin
            unique case (state_q)
                MANUAL: if (auto_en) state_d = ROTATE;
                ROTATE: begin
                    if (!auto_en)        state_d = MANUAL;
                    else if (|pending)   state_d = PIN;
                end
                PIN: begin
                    if (!auto_en)                    state_d = MANUAL;
                    else if (hold_done && !pick_found) state_d = ROTATE;
                end
                default: state_d = MANUAL;
            endcase
        end
    end

    // next channel select, grant, counters and pointers
    always_comb begin
        test_nx  = Test;
        grant_nx = grant;
        dwell_nx = dwell_cnt;
        hold_nx  = hold_cnt;
        rot_nx   = rot_ptr;
        rr_nx    = rr_ptr;
        pend_clr = '0;
        if (!freeze) begin
            unique case (state_q)
                MANUAL: begin
                    test_nx = man_sel;
                    if (auto_en) begin
                        rot_nx   = man_sel;
                        dwell_nx = '0;
                    end
                end
                ROTATE: begin
                    if (!auto_en) begin
                        test_nx  = man_sel;
                        grant_nx = '0;
                        pend_clr = '1;
                        hold_nx  = '0;
                    end else if (|pending) begin
                        test_nx  = pick_ch;
                        grant_nx = ch_onehot(pick_ch);
                        hold_nx  = '0;
                    end else begin
                        test_nx = rot_ptr;
                        if (dwell_done) begin
                            rot_nx   = rot_ptr + 3'd1;
                            dwell_nx = '0;
                        end else begin
                            dwell_nx = dwell_inc[DWELL_W-1:0];
                        end
                    end
                end
                PIN: begin
                    if (!auto_en) begin
                        test_nx  = man_sel;
                        grant_nx = '0;
                        pend_clr = '1;
                        hold_nx  = '0;
                    end else if (hold_done) begin
                        pend_clr = pin_mask;
                        rr_nx    = Test + 3'd1;
                        hold_nx  = '0;
                        if (pick_found) begin
                            test_nx  = pick_ch;
                            grant_nx = ch_onehot(pick_ch);
                        end else begin
                            test_nx  = rot_ptr;
                            grant_nx = '0;
                            dwell_nx = '0;
                        end
                    end else begin
                        hold_nx = hold_cnt + HOLD_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // registered outputs and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Test      <= '0;
            grant     <= '0;
            dwell_cnt <= '0;
            hold_cnt  <= '0;
            rot_ptr   <= '0;
            rr_ptr    <= '0;
        end else begin
            Test      <= test_nx;
            grant     <= grant_nx;
            dwell_cnt <= dwell_nx;
            hold_cnt  <= hold_nx;
            rot_ptr   <= rot_nx;
            rr_ptr    <= rr_nx;
        end
    end

endmodule

// File: tb/tb_disp_chan_scheduler.sv
// tb/tb_disp_chan_scheduler.sv - self-checking bench for disp_chan_scheduler
module tb_disp_chan_scheduler;

    localparam int DW    = 8;
    localparam int HOLD  = 4;
    localparam int M_MAN = 0;
    localparam int M_ROT = 1;
    localparam int M_PIN = 2;

    logic          clk;
    logic          rst;
    logic          auto_en;
    logic [2:0]    man_sel;
    logic [DW-1:0] dwell_cyc;
    logic [7:0]    req;
    logic          cpu_wr;
    logic          freeze;
    logic [2:0]    Test;
    logic          EN;
    logic [7:0]    grant;
    logic [7:0]    pending;

    int n_tests = 0;
    int n_fail  = 0;
    int rot_exp [13] = '{6, 6, 6, 6, 7, 7, 7, 0, 0, 0, 1, 1, 1};

    int         m_mode  = M_MAN;
    int         m_test  = 0;
    int         m_pin   = -1;
    int         m_dwell = 0;
    int         m_hold  = 0;
    int         m_rot   = 0;
    int         m_rr    = 0;
    logic [7:0] m_pend  = 8'h00;
    logic [7:0] m_req_prev = 8'h00;
    logic       m_wr_prev  = 1'b0;
    logic       m_en       = 1'b0;
    logic [7:0] m_edge;
    logic       m_en_nx;
    int         m_lim;

    disp_chan_scheduler #(.DWELL_W(DW), .HOLD_CYC(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .auto_en   (auto_en),
        .man_sel   (man_sel),
        .dwell_cyc (dwell_cyc),
        .req       (req),
        .cpu_wr    (cpu_wr),
        .freeze    (freeze),
        .Test      (Test),
        .EN        (EN),
        .grant     (grant),
        .pending   (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_search(input logic [7:0] p, input int start);
        for (int k = 0; k < 8; k++) begin
            if (p[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    // reference model: one step of the scheduling rules per clock
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = M_MAN; m_test = 0; m_pin = -1; m_dwell = 0; m_hold = 0;
            m_rot = 0; m_rr = 0; m_pend = 8'h00; m_req_prev = 8'h00;
            m_wr_prev = 1'b0; m_en = 1'b0;
        end else begin
            m_edge  = req & ~m_req_prev;
            m_en_nx = cpu_wr && !m_wr_prev && !freeze;
            if (!freeze) begin
                if (m_mode == M_MAN) begin
                    m_test = int'(man_sel);
                    if (auto_en) begin
                        m_mode = M_ROT; m_rot = int'(man_sel); m_dwell = 0;
                    end
                end else if (!auto_en) begin
                    m_mode = M_MAN; m_test = int'(man_sel); m_pend = 8'h00;
                    m_pin = -1; m_hold = 0;
                end else if (m_mode == M_ROT) begin
                    if (m_pend != 8'h00) begin
                        m_pin = rr_search(m_pend, m_rr);
                        m_mode = M_PIN; m_test = m_pin; m_hold = 0;
                    end else begin
                        m_test = m_rot;
                        m_lim  = (dwell_cyc == 0) ? 1 : int'(dwell_cyc);
                        m_dwell = m_dwell + 1;
                        if (m_dwell >= m_lim) begin
                            m_rot = (m_rot + 1) % 8; m_dwell = 0;
                        end
                    end
                end else begin
                    if (m_hold == HOLD - 1) begin
                        m_pend[m_pin] = 1'b0;
                        m_rr   = (m_pin + 1) % 8;
                        m_hold = 0;
                        if (m_pend != 8'h00) begin
                            m_pin  = rr_search(m_pend, m_rr);
                            m_test = m_pin;
                        end else begin
                            m_pin = -1; m_mode = M_ROT; m_test = m_rot; m_dwell = 0;
                        end
                    end else begin
                        m_hold = m_hold + 1;
                    end
                end
            end
            m_pend     = m_pend | m_edge;
            m_req_prev = req;
            m_wr_prev  = cpu_wr;
            m_en       = m_en_nx;
        end
    end

    // compare DUT outputs against the model every cycle
    always @(negedge clk) begin
        check("cmp_test", int'(Test), m_test);
        check("cmp_en", int'(EN), int'(m_en));
        check("cmp_grant", int'(grant), (m_pin < 0) ? 0 : (1 << m_pin));
        check("cmp_pending", int'(pending), int'(m_pend));
    end

    task automatic wait_grant(input string name, input bit want_set);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if ((grant != 8'h00) == want_set) seen = 1'b1;
        end
        check(name, int'(seen), 1);
    endtask

    initial begin
        int prev;
        int t0;
        int en_cnt;
        rst = 1'b1; auto_en = 1'b0; man_sel = 3'd5; dwell_cyc = '0;
        req = 8'h00; cpu_wr = 1'b0; freeze = 1'b0;
        #1 rst = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_test", int'(Test), 0);
        check("rst_grant", int'(grant), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_en", int'(EN), 0);
        rst = 1'b1;
        @(negedge clk);
        check("manual_test", int'(Test), 5);
        check("manual_grant", int'(grant), 0);

        auto_en = 1'b1; man_sel = 3'd6; dwell_cyc = 8'd3;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            check("rotate_seq", int'(Test), rot_exp[i]);
        end
        dwell_cyc = 8'd0;
        prev = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rotate_fast", int'(Test), (prev + 1) % 8);
            prev = int'(Test);
        end

        dwell_cyc = 8'd200;
        repeat (2) @(negedge clk);
        t0 = int'(Test);
        req = 8'h02;
        @(negedge clk);
        req = 8'h00;
        check("pin1_pending", int'(pending), 8'h02);
        wait_grant("pin1_on", 1'b1);
        check("pin1_grant", int'(grant), 8'h02);
        wait_grant("pin1_off", 1'b0);
        check("pin1_resume", int'(Test), t0);

        req = 8'h12;
        @(negedge clk);
        req = 8'h00;
        check("pair_pending", int'(pending), 8'h12);
        check("pair_grant0", int'(grant), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("pin4_grant", int'(grant), 8'h10);
            check("pin4_test", int'(Test), 4);
            check("pin4_pending", int'(pending), 8'h12);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("pin1b_grant", int'(grant), 8'h02);
            check("pin1b_test", int'(Test), 1);
            check("pin1b_pending", int'(pending), 8'h02);
        end
        @(negedge clk);
        check("resume_grant", int'(grant), 0);
        check("resume_test", int'(Test), t0);
        check("resume_pending", int'(pending), 0);
        @(negedge clk);
        check("resume_dwell", int'(Test), t0);

        req = 8'h50;
        @(negedge clk);
        req = 8'h00;
        wait_grant("exit_pin_on", 1'b1);
        check("exit_pin_grant", int'(grant), 8'h10);
        auto_en = 1'b0; man_sel = 3'd3;
        @(negedge clk);
        check("exit_test", int'(Test), 3);
        check("exit_grant", int'(grant), 0);
        check("exit_pending", int'(pending), 0);

        cpu_wr = 1'b1;
        en_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            en_cnt += int'(EN);
            if (i == 4) cpu_wr = 1'b0;
        end
        check("en_single", en_cnt, 1);

        freeze = 1'b1;
        @(negedge clk);
        cpu_wr = 1'b1; man_sel = 3'd7; req = 8'h04;
        @(negedge clk);
        req = 8'h00;
        en_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            en_cnt += int'(EN);
            if (i == 3) cpu_wr = 1'b0;
        end
        check("freeze_no_en", en_cnt, 0);
        check("freeze_test", int'(Test), 3);
        check("freeze_pending", int'(pending), 8'h04);
        freeze = 1'b0;
        @(negedge clk);
        check("unfreeze_test", int'(Test), 7);
        check("unfreeze_pending", int'(pending), 8'h04);

        auto_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 49) == 0) auto_en = ($urandom_range(0, 3) != 0);
            man_sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) dwell_cyc = 8'($urandom_range(0, 5));
            if ($urandom_range(0, 5) == 0) req = req ^ 8'(1 << $urandom_range(0, 7));
            cpu_wr = ($urandom_range(0, 2) == 0);
            if (freeze) freeze = ($urandom_range(0, 3) != 0);
            else        freeze = ($urandom_range(0, 39) == 0);
        end

        freeze = 1'b0; auto_en = 1'b1; req = 8'h00; cpu_wr = 1'b0;
        @(negedge clk);
        req = 8'h08;
        @(negedge clk);
        req = 8'h00;
        wait_grant("pre_rst_pin", 1'b1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_test", int'(Test), 0);
        check("async_rst_grant", int'(grant), 0);
        check("async_rst_pending", int'(pending), 0);
        check("async_rst_en", int'(EN), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
